// File: rtl/rf_seq_ctrl_pkg.sv
// Shared definitions for the register-file micro-sequencer:
// opcode constants, FSM state codes and small decode helpers.
package rf_ctrl_defs;

    localparam int OP_W    = 3;
    localparam int STATE_W = 2;

    // Command opcodes
    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_LDI = 3'b001;
    localparam logic [OP_W-1:0] OP_MOV = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_AND = 3'b101;
    localparam logic [OP_W-1:0] OP_OR  = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR = 3'b111;

    // Sequencer states
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RD_A = 2'd1;
    localparam logic [STATE_W-1:0] S_RD_B = 2'd2;
    localparam logic [STATE_W-1:0] S_WR   = 2'd3;

    // True for the two-operand opcodes, which need a second read cycle.
    function automatic logic op_needs_b(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    // First state after accepting a command: NOP completes from IDLE,
    // LDI needs no operand read, everything else reads src_a first.
    function automatic logic [STATE_W-1:0] entry_state(input logic [OP_W-1:0] op);
        logic [STATE_W-1:0] st;
        case (op)
            OP_NOP:  st = S_IDLE;
            OP_LDI:  st = S_WR;
            default: st = S_RD_A;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rf_seq_ctrl_alu.sv
// Combinational ALU for the sequencer: selects the write-back value and
// derives the carry/borrow and zero flags for the executing opcode.
module rf_alu
    import rf_ctrl_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             z
);

    // One extra bit keeps the carry out of the add and the borrow of the subtract.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Result and carry/borrow selection per opcode
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result = '0;
        c      = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_MOV: result = a;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
            end
            OP_SUB: begin
                // The borrow out of the widened subtract is set exactly when a < b.
                result = diff[WIDTH-1:0];
                c      = diff[WIDTH];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/rf_seq_ctrl.sv
// Micro-sequencer executing register-transfer commands on a register file
// with one combinational read port: operands are read serially (src_a, then
// src_b), combined in rf_alu, and written back through the write port.
module rf_seq_ctrl
    import rf_ctrl_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    // Command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [WIDTH-1:0] cmd_imm,
    // Register file interface
    output logic [AW-1:0]    rf_rsel,
    input  logic [WIDTH-1:0] rf_q,
    output logic             rf_en,
    output logic [AW-1:0]    rf_wsel,
    output logic [WIDTH-1:0] rf_d,
    // Completion and flags
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             flag_z,
    output logic             flag_c
);

    logic [STATE_W-1:0] state_q, state_d;

    // Command fields captured at acceptance
    logic [OP_W-1:0]  op_q;
    logic [AW-1:0]    dst_q;
    logic [AW-1:0]    src_a_q;
    logic [AW-1:0]    src_b_q;
    logic [WIDTH-1:0] imm_q;

    // Operands read from the register file
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Response and flags
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             flag_z_q,    flag_z_d;
    logic             flag_c_q,    flag_c_d;

    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_z;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // The ALU only sees latched fields, so the write-back value is stable for the whole WR cycle.
    rf_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result),
        .c      (alu_c),
        .z      (alu_z)
    );

    // Next-state decode: IDLE -> (RD_A -> (RD_B) ->) WR -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = entry_state(cmd_op);
            S_RD_A: state_d = op_needs_b(op_q) ? S_RD_B : S_WR;
            S_RD_B: state_d = S_WR;
            S_WR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight command before its write.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Capture all command fields on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            imm_q   <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            imm_q   <= cmd_imm;
        end
    end

    // Operand capture from the combinational read port during the read states.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (state_q == S_RD_A) a_q <= rf_q;
            if (state_q == S_RD_B) b_q <= rf_q;
        end
    end

    // Register-file drive decoded from state and latched fields only.
    always_comb begin
        rf_rsel = '0;
        rf_en   = 1'b0;
        rf_wsel = '0;
        rf_d    = '0;
        case (state_q)
            S_RD_A: rf_rsel = src_a_q;
            S_RD_B: rf_rsel = src_b_q;
            S_WR: begin
                rf_en   = 1'b1;
                rf_wsel = dst_q;
                rf_d    = alu_result;
            end
            default: ;
        endcase
    end

    // Completion: a writing command reports its result and flags the cycle
    // after WR; a NOP pulses rsp_valid without touching data or flags.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        if (state_q == S_WR) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_result;
            flag_z_d    = alu_z;
            flag_c_d    = alu_c;
        end else if (accept && (cmd_op == OP_NOP)) begin
            rsp_valid_d = 1'b1;
        end
    end

    // Response and flag registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: a behavioural register-file + command
// model, a per-cycle compare process, and directed scenarios with literal
// expectations taken from hand calculation.
module tb_rf_seq_ctrl;

    localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, AND = 3'd5, OR  = 3'd6, XOR = 3'd7;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src_a;
    logic [2:0] cmd_src_b;
    logic [7:0] cmd_imm;
    logic [2:0] rf_rsel;
    logic [7:0] rf_q;
    logic       rf_en;
    logic [2:0] rf_wsel;
    logic [7:0] rf_d;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       flag_z;
    logic       flag_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rf_seq_ctrl #(.WIDTH(8), .AW(3)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_imm   (cmd_imm),
        .rf_rsel   (rf_rsel),
        .rf_q      (rf_q),
        .rf_en     (rf_en),
        .rf_wsel   (rf_wsel),
        .rf_d      (rf_d),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    // Register file seen by the DUT (not cleared by clr_n)
    logic [7:0] tb_rf [8] = '{default: 8'h00};
    assign rf_q = tb_rf[rf_rsel];
    always @(posedge clk) if (rf_en) tb_rf[rf_wsel] <= rf_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted command becomes a list of bus cycles (reads then one write);
    // completion is reported the cycle after its write.
    typedef enum {K_RD, K_WR} kind_e;
    typedef struct { kind_e kind; logic [2:0] sel; logic [7:0] d; } step_t;

    step_t      plan[$];
    logic [7:0] m_rf [8] = '{default: 8'h00};
    logic [7:0] p_res;
    logic [2:0] p_dst;
    logic       p_z, p_c;
    logic       m_rsp_valid = 1'b0;
    logic [7:0] m_rsp_data = 8'h00;
    logic       m_z = 1'b0, m_c = 1'b0;
    int         m_a, m_b, m_r;
    step_t      m_s;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            plan.delete();
            m_rsp_valid = 1'b0;
            m_rsp_data  = 8'h00;
            m_z = 1'b0;
            m_c = 1'b0;
        end else begin
            m_rsp_valid = 1'b0;
            if (plan.size() != 0) begin
                m_s = plan.pop_front();
                if (m_s.kind == K_WR) begin
                    m_rf[p_dst] = p_res;
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = p_res;
                    m_z = p_z;
                    m_c = p_c;
                end
            end else if (cmd_valid) begin
                m_a = int'(m_rf[cmd_src_a]);
                m_b = int'(m_rf[cmd_src_b]);
                p_c = 1'b0;
                case (cmd_op)
                    LDI: m_r = int'(cmd_imm);
                    MOV: m_r = m_a;
                    ADD: begin m_r = m_a + m_b; p_c = (m_r > 255); end
                    SUB: begin m_r = m_a - m_b + 256; p_c = (m_a < m_b); end
                    AND: m_r = m_a & m_b;
                    OR:  m_r = m_a | m_b;
                    XOR: m_r = m_a ^ m_b;
                    default: m_r = 0;
                endcase
                m_r   = m_r % 256;
                p_res = 8'(m_r);
                p_z   = (m_r == 0);
                p_dst = cmd_dst;
                if (cmd_op == NOP) begin
                    m_rsp_valid = 1'b1;
                end else begin
                    if (cmd_op != LDI) plan.push_back('{K_RD, cmd_src_a, 8'h00});
                    if (cmd_op >= ADD) plan.push_back('{K_RD, cmd_src_b, 8'h00});
                    plan.push_back('{K_WR, cmd_dst, p_res});
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic       c_busy, c_rd, c_wr;
    logic [2:0] c_sel;
    logic [7:0] c_d;
    logic       watch_en = 1'b0;
    logic       en_seen  = 1'b0;

    always @(negedge clk) begin
        c_busy = (plan.size() != 0);
        c_rd = 1'b0; c_wr = 1'b0; c_sel = 3'd0; c_d = 8'h00;
        if (c_busy) begin
            c_rd  = (plan[0].kind == K_RD);
            c_wr  = (plan[0].kind == K_WR);
            c_sel = plan[0].sel;
            c_d   = plan[0].d;
        end
        check("cyc cmd_ready", 32'(cmd_ready), 32'(!c_busy));
        check("cyc rf_en",     32'(rf_en),     32'(c_wr));
        if (!c_wr) check("cyc rf_rsel", 32'(rf_rsel), 32'(c_rd ? c_sel : 3'd0));
        if (!c_rd) begin
            check("cyc rf_wsel", 32'(rf_wsel), 32'(c_wr ? c_sel : 3'd0));
            check("cyc rf_d",    32'(rf_d),    32'(c_d));
        end
        check("cyc rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("cyc rsp_data",  32'(rsp_data),  32'(m_rsp_data));
        check("cyc flag_z",    32'(flag_z),    32'(m_z));
        check("cyc flag_c",    32'(flag_c),    32'(m_c));
        if (watch_en && rf_en) en_seen = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a command and return in the first cycle after its acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                         input logic [2:0] sb, input logic [7:0] imm, input bit keep_valid);
        int  n = 0;
        logic rdy;
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
        do begin
            rdy = cmd_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        check("accept", 32'(rdy), 32'd1);
        if (!keep_valid) begin
            cmd_valid = 1'b0;
            cmd_op = ~op; cmd_dst = ~dst; cmd_src_a = ~sa; cmd_src_b = ~sb; cmd_imm = ~imm;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        clr_n = 1'b1;
        cmd_valid = 1'b0; cmd_op = NOP; cmd_dst = 3'd0;
        cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_imm = 8'h00;
        #1 clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 clr_n = 1'b1;
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        tick();

        // LDI r1 = 0x5A, LDI r2 = 0xA6
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h5A, 1'b0);
        check("ldi1 rf_en",   32'(rf_en),   32'd1);
        check("ldi1 rf_wsel", 32'(rf_wsel), 32'd1);
        check("ldi1 rf_d",    32'(rf_d),    32'h5A);
        tick();
        check("ldi1 rsp_valid", 32'(rsp_valid), 32'd1);
        check("ldi1 rsp_data",  32'(rsp_data),  32'h5A);
        tick();
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'hA6, 1'b0);
        check("ldi2 rf_wsel", 32'(rf_wsel), 32'd2);
        check("ldi2 rf_d",    32'(rf_d),    32'hA6);
        tick();
        check("ldi2 rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        issue(LDI, 3'd6, 3'd0, 3'd0, 8'h33, 1'b0);
        ticks(2);

        // ADD r3 = r1 + r2 = 0x100 -> 0x00, carry
        issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0);
        check("add rsel a", 32'(rf_rsel), 32'd1);
        tick();
        check("add rsel b", 32'(rf_rsel), 32'd2);
        tick();
        check("add rf_en",   32'(rf_en),   32'd1);
        check("add rf_wsel", 32'(rf_wsel), 32'd3);
        check("add rf_d",    32'(rf_d),    32'h00);
        tick();
        check("add rsp_valid", 32'(rsp_valid), 32'd1);
        check("add rsp_data",  32'(rsp_data),  32'h00);
        check("add flag_z",    32'(flag_z),    32'd1);
        check("add flag_c",    32'(flag_c),    32'd1);
        tick();

        // SUB r4 = r1 - r2 = 0xB4 with borrow
        issue(SUB, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0);
        ticks(2);
        check("sub rf_d", 32'(rf_d), 32'hB4);
        tick();
        check("sub flag_c", 32'(flag_c), 32'd1);
        check("sub flag_z", 32'(flag_z), 32'd0);
        tick();

        // XOR r1 = r1 ^ r1 -> 0
        issue(XOR, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0);
        ticks(2);
        check("xor rf_d", 32'(rf_d), 32'h00);
        tick();
        check("xor flag_c", 32'(flag_c), 32'd0);
        check("xor flag_z", 32'(flag_z), 32'd1);
        tick();
        check("xor r1 stored", 32'(tb_rf[1]), 32'h00);
        issue(MOV, 3'd7, 3'd1, 3'd0, 8'h00, 1'b0);
        ticks(2);
        check("mov r1 readback", 32'(rsp_data), 32'h00);
        tick();

        // OR / AND of r4 (0xB4) and r2 (0xA6)
        issue(OR, 3'd7, 3'd4, 3'd2, 8'h00, 1'b0);
        ticks(3);
        check("or rsp_data", 32'(rsp_data), 32'hB6);
        tick();
        issue(AND, 3'd7, 3'd4, 3'd2, 8'h00, 1'b0);
        ticks(3);
        check("and rsp_data", 32'(rsp_data), 32'hA4);
        tick();

        // Back-to-back: MOV r5 = r2, then NOP with cmd_valid held high
        issue(MOV, 3'd5, 3'd2, 3'd0, 8'h00, 1'b1);
        cmd_op = NOP; cmd_dst = 3'd7; cmd_src_a = 3'd7; cmd_imm = 8'hFF;
        check("b2b busy1 ready", 32'(cmd_ready), 32'd0);
        tick();
        check("b2b busy2 ready", 32'(cmd_ready), 32'd0);
        tick();
        check("b2b mov rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b mov rsp_data",  32'(rsp_data),  32'hA6);
        check("b2b mov ready",     32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("b2b nop rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b nop rsp_data",  32'(rsp_data),  32'hA6);
        tick();
        check("b2b after rsp_valid", 32'(rsp_valid), 32'd0);
        check("b2b r5", 32'(tb_rf[5]), 32'hA6);

        // SUB r0 = r1 - r2 = 0 - 0xA6 = 0x5A, borrow
        issue(SUB, 3'd0, 3'd1, 3'd2, 8'h00, 1'b0);
        ticks(3);
        check("sub2 rsp_data", 32'(rsp_data), 32'h5A);
        check("sub2 flag_c",   32'(flag_c),   32'd1);
        tick();

        // Reset while ADD r6 = r1 + r2 is in RD_B
        watch_en = 1'b1;
        issue(ADD, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0);
        tick();
        check("abort in rd_b", 32'(rf_rsel), 32'd2);
        clr_n = 1'b0;
        #1;
        check("rst rf_en",     32'(rf_en),     32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data",  32'(rsp_data),  32'h00);
        check("rst flag_z",    32'(flag_z),    32'd0);
        check("rst flag_c",    32'(flag_c),    32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        ticks(2);
        clr_n = 1'b1;
        ticks(3);
        watch_en = 1'b0;
        check("abort no write en", 32'(en_seen),   32'd0);
        check("abort r6 kept",     32'(tb_rf[6]),  32'h33);
        check("post-rst ready",    32'(cmd_ready), 32'd1);
        issue(LDI, 3'd0, 3'd0, 3'd0, 8'hC3, 1'b0);
        tick();
        check("post-rst ldi rsp_valid", 32'(rsp_valid), 32'd1);
        check("post-rst ldi rsp_data",  32'(rsp_data),  32'hC3);
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
